// File: rtl/core_bus_pkg.sv
// Shared definitions for the core data-bus path: bus widths and bridge states.
package core_bus_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    localparam logic [BE_W-1:0] BE_ALL = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQUEST   = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } bridge_state_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating cycle counter that flags when an outstanding access has used up
// its allowed number of cycles. TIMEOUT_CYCLES = 0 disables expiry.
module bus_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    // expired is raised in the last allowed cycle so the bridge leaves on that edge
    localparam logic [CW-1:0] LAST  = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Count active cycles, saturating at the limit so it never wraps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    // Expiry is only meaningful while counting and when a limit is configured
    always_comb begin
        expired = 1'b0;
        if ((TIMEOUT_CYCLES != 0) && enable && (count >= LAST)) begin
            expired = 1'b1;
        end
    end

endmodule

// File: rtl/data_bus_bridge.sv
// Bridges the LSU single-cycle data port onto the valid/ready data-memory
// interconnect: captures one access, issues it, waits for the response,
// stalls the pipeline throughout and turns a hung access into a fault.
module data_bus_bridge
    import core_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] bus_address,
    input  logic [XLEN-1:0] bus_write_data,
    input  logic [BE_W-1:0] bus_byte_enable,
    input  logic            bus_write_enable,
    input  logic            bus_read_enable,
    output logic [XLEN-1:0] bus_read_data,
    output logic            memory_stall,
    output logic            access_fault,
    output logic            request_valid,
    input  logic            request_ready,
    output logic [XLEN-1:0] request_address,
    output logic            request_write,
    output logic [XLEN-1:0] request_write_data,
    output logic [BE_W-1:0] request_byte_enable,
    input  logic            response_valid,
    input  logic [XLEN-1:0] response_read_data
);

    bridge_state_t state, next_state;

    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [BE_W-1:0] be_q;
    logic            write_q;
    logic [XLEN-1:0] rdata_q;
    logic            fault_q;

    logic capture;
    logic take_resp;
    logic timeout_hit;
    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; timeout takes priority over handshake and response
    always_comb begin
        next_state   = state;
        capture      = 1'b0;
        take_resp    = 1'b0;
        timeout_hit  = 1'b0;
        timer_clear  = 1'b1;
        timer_enable = 1'b0;
        case (state)
            IDLE: begin
                if (bus_write_enable || bus_read_enable) begin
                    capture    = 1'b1;
                    next_state = REQUEST;
                end
            end
            REQUEST: begin
                timer_clear  = 1'b0;
                timer_enable = 1'b1;
                if (timer_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = DONE;
                end else if (request_ready) begin
                    next_state = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                timer_clear  = 1'b0;
                timer_enable = 1'b1;
                if (timer_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = DONE;
                end else if (response_valid) begin
                    take_resp  = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Capture the LSU access, the returned word and the one-cycle fault flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            fault_q <= timeout_hit;
            if (capture) begin
                addr_q  <= bus_address;
                wdata_q <= bus_write_data;
                write_q <= bus_write_enable;
                be_q    <= bus_write_enable ? bus_byte_enable : BE_ALL;
            end
            if (take_resp) begin
                rdata_q <= write_q ? '0 : response_read_data;
            end else if (timeout_hit) begin
                rdata_q <= '0;
            end
        end
    end

    assign request_valid       = (state == REQUEST);
    assign request_address     = addr_q;
    assign request_write       = write_q;
    assign request_write_data  = wdata_q;
    assign request_byte_enable = be_q;
    assign bus_read_data       = rdata_q;
    assign access_fault        = fault_q;
    assign memory_stall        = (bus_read_enable || bus_write_enable) && (state != DONE);

endmodule
